// File: rtl/ex_alu_pkg.sv
// Shared constants and control encodings for the ex_alu_unit execute stage.
package ex_alu_pkg;

  localparam int XLEN  = 32;
  localparam int LANES = 4;

  localparam logic [2:0] ALU_OP_ADD = 3'b000;
  localparam logic [2:0] ALU_OP_BR  = 3'b001;
  localparam logic [2:0] ALU_OP_R   = 3'b010;
  localparam logic [2:0] ALU_OP_I   = 3'b011;
  localparam logic [2:0] ALU_OP_LUI = 3'b100;
  localparam logic [2:0] ALU_OP_MAT = 3'b101;
  localparam logic [2:0] ALU_OP_JMP = 3'b110;

  typedef enum logic [4:0] {
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASSB,
    BEQ, BNE, BLT, BGE, BLTU, BGEU, JMP,
    MADDS, MMULS, MSUM, MINS, MEXT, MTRANS, MADD, MBCAST,
    NOP
  } ctrl_e;

endpackage

// File: rtl/ex_alu_decoder.sv
// Combinational decode of alu_op/func3/func7 into the internal ALU control code.
module ex_alu_decoder
  import ex_alu_pkg::*;
(
  input  logic [2:0] alu_op,
  input  logic [2:0] func3,
  input  logic       func7,
  output ctrl_e      ctrl
);

  always_comb begin
    ctrl = NOP;
    case (alu_op)
      ALU_OP_ADD: ctrl = ADD;
      ALU_OP_BR: begin
        case (func3)
          3'b000:  ctrl = BEQ;
          3'b001:  ctrl = BNE;
          3'b100:  ctrl = BLT;
          3'b101:  ctrl = BGE;
          3'b110:  ctrl = BLTU;
          3'b111:  ctrl = BGEU;
          default: ctrl = SUB;
        endcase
      end
      // I-type shares R-type decode, but func7 only selects SUB for register ops
      ALU_OP_R, ALU_OP_I: begin
        case (func3)
          3'b000:  ctrl = (alu_op == ALU_OP_R && func7) ? SUB : ADD;
          3'b001:  ctrl = SLL;
          3'b010:  ctrl = SLT;
          3'b011:  ctrl = SLTU;
          3'b100:  ctrl = XOR;
          3'b101:  ctrl = func7 ? SRA : SRL;
          3'b110:  ctrl = OR;
          default: ctrl = AND;
        endcase
      end
      ALU_OP_LUI: ctrl = PASSB;
      ALU_OP_MAT: begin
        case (func3)
          3'b000:  ctrl = MADDS;
          3'b001:  ctrl = MMULS;
          3'b010:  ctrl = MSUM;
          3'b011:  ctrl = MINS;
          3'b100:  ctrl = MEXT;
          3'b101:  ctrl = MTRANS;
          3'b110:  ctrl = MADD;
          default: ctrl = MBCAST;
        endcase
      end
      ALU_OP_JMP: ctrl = JMP;
      default:    ctrl = ADD;
    endcase
  end

endmodule

// File: rtl/ex_alu_unit.sv
// Registered execute-stage ALU: scalar result, 4-lane matrix result and branch mark.
// Define MATRIX_MUL_EN to build the per-lane multipliers used by MMULS.
module ex_alu_unit
  import ex_alu_pkg::*;
#(
  parameter int XLEN  = ex_alu_pkg::XLEN,
  parameter int LANES = ex_alu_pkg::LANES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [2:0]            alu_op,
  input  logic [2:0]            func3_code,
  input  logic                  func7_code,
  input  logic [XLEN-1:0]       op_A,
  input  logic [XLEN-1:0]       op_B,
  input  logic [XLEN*LANES-1:0] op_matrix,
  output logic                  out_valid,
  output logic [XLEN-1:0]       alu_o,
  output logic [XLEN*LANES-1:0] matrix_o,
  output logic                  br_mark
);

  localparam int SHW = $clog2(XLEN);
  localparam int LSW = $clog2(LANES);

  ctrl_e                  ctrl;
  logic [XLEN-1:0]        alu_n;
  logic [XLEN*LANES-1:0]  mat_n;
  logic                   br_n;
  logic [SHW-1:0]         shamt;
  logic [LSW-1:0]         ins_idx;
  logic [LSW-1:0]         ext_idx;
  logic [XLEN-1:0]        diff;

  ex_alu_decoder u_dec (
    .alu_op (alu_op),
    .func3  (func3_code),
    .func7  (func7_code),
    .ctrl   (ctrl)
  );

  assign shamt   = op_B[SHW-1:0];
  assign ins_idx = op_A[LSW-1:0];
  assign ext_idx = op_B[LSW-1:0];
  assign diff    = op_A - op_B;

  always_comb begin
    alu_n = '0;
    mat_n = op_matrix;
    br_n  = 1'b0;
    case (ctrl)
      ADD:   alu_n = op_A + op_B;
      SUB:   alu_n = diff;
      SLL:   alu_n = op_A << shamt;
      SLT:   alu_n = {{(XLEN-1){1'b0}}, $signed(op_A) < $signed(op_B)};
      SLTU:  alu_n = {{(XLEN-1){1'b0}}, op_A < op_B};
      XOR:   alu_n = op_A ^ op_B;
      SRL:   alu_n = op_A >> shamt;
      SRA:   alu_n = $signed(op_A) >>> shamt;
      OR:    alu_n = op_A | op_B;
      AND:   alu_n = op_A & op_B;
      PASSB: alu_n = op_B;
      // Branch compares still expose A-B on the scalar result
      BEQ:  begin alu_n = diff; br_n = (op_A == op_B); end
      BNE:  begin alu_n = diff; br_n = (op_A != op_B); end
      BLT:  begin alu_n = diff; br_n = ($signed(op_A) <  $signed(op_B)); end
      BGE:  begin alu_n = diff; br_n = ($signed(op_A) >= $signed(op_B)); end
      BLTU: begin alu_n = diff; br_n = (op_A <  op_B); end
      BGEU: begin alu_n = diff; br_n = (op_A >= op_B); end
      JMP:  begin alu_n = op_A + op_B; br_n = 1'b1; end
      MADDS: begin
        for (int i = 0; i < LANES; i++)
          mat_n[i*XLEN +: XLEN] = op_matrix[i*XLEN +: XLEN] + op_B;
      end
      MMULS: begin
`ifdef MATRIX_MUL_EN
        for (int i = 0; i < LANES; i++)
          mat_n[i*XLEN +: XLEN] = op_matrix[i*XLEN +: XLEN] * op_B;
`else
        mat_n = op_matrix;
`endif
      end
      MSUM: begin
        for (int i = 0; i < LANES; i++)
          alu_n = alu_n + op_matrix[i*XLEN +: XLEN];
      end
      MINS:   mat_n[int'(ins_idx)*XLEN +: XLEN] = op_B;
      MEXT:   alu_n = op_matrix[int'(ext_idx)*XLEN +: XLEN];
      // 2x2 row-major transpose only exchanges the off-diagonal lanes
      MTRANS: begin
        mat_n[1*XLEN +: XLEN] = op_matrix[2*XLEN +: XLEN];
        mat_n[2*XLEN +: XLEN] = op_matrix[1*XLEN +: XLEN];
      end
      MADD: begin
        for (int i = 0; i < LANES; i++)
          mat_n[i*XLEN +: XLEN] = op_matrix[i*XLEN +: XLEN] + op_A;
        alu_n = op_matrix[XLEN-1:0];
      end
      MBCAST: begin
        mat_n = {LANES{op_B}};
        alu_n = op_B;
      end
      default: alu_n = '0;
    endcase
  end

  // Data registers only load on valid so idle cycles keep the last result visible
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      alu_o     <= '0;
      matrix_o  <= '0;
      br_mark   <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        alu_o    <= alu_n;
        matrix_o <= mat_n;
        br_mark  <= br_n;
      end
    end
  end

endmodule

// File: tb/tb_ex_alu_unit.sv
// Scoreboard bench for ex_alu_unit: directed vectors with hand-computed results.
module tb_ex_alu_unit;
  import ex_alu_pkg::*;

  typedef struct {
    string        name;
    logic [31:0]  alu;
    logic [127:0] mat;
    logic         br;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [2:0]   alu_op = '0;
  logic [2:0]   func3_code = '0;
  logic         func7_code = 1'b0;
  logic [31:0]  op_A = '0;
  logic [31:0]  op_B = '0;
  logic [127:0] op_matrix = '0;
  logic         out_valid;
  logic [31:0]  alu_o;
  logic [127:0] matrix_o;
  logic         br_mark;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done = 1'b0;

  localparam logic [127:0] M    = {32'd4, 32'd3, 32'd2, 32'd1};
  localparam logic [127:0] MBIG = {4{32'h0001_0000}};

  ex_alu_unit dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .alu_op     (alu_op),
    .func3_code (func3_code),
    .func7_code (func7_code),
    .op_A       (op_A),
    .op_B       (op_B),
    .op_matrix  (op_matrix),
    .out_valid  (out_valid),
    .alu_o      (alu_o),
    .matrix_o   (matrix_o),
    .br_mark    (br_mark)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input string name, input logic [2:0] op, input logic [2:0] f3,
                               input logic f7, input logic [31:0] a, input logic [31:0] b,
                               input logic [127:0] m, input logic [31:0] e_alu,
                               input logic [127:0] e_mat, input logic e_br);
    exp_t e;
    @(negedge clk);
    alu_op = op; func3_code = f3; func7_code = f7;
    op_A = a; op_B = b; op_matrix = m; in_valid = 1'b1;
    e.name = name; e.alu = e_alu; e.mat = e_mat; e.br = e_br;
    exp_q.push_back(e);
  endtask

  // Monitor: every presented result must match the oldest outstanding expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_valid: got out_valid=1, expected no result");
        end else begin
          e = exp_q.pop_front();
          checkOutput({e.name, "_alu"}, {96'd0, alu_o}, {96'd0, e.alu});
          checkOutput({e.name, "_mat"}, matrix_o, e.mat);
          checkOutput({e.name, "_br"}, {127'd0, br_mark}, {127'd0, e.br});
        end
      end
    end
  end

  task automatic drain();
    int n = 0;
    @(negedge clk);
    in_valid = 1'b0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d outstanding results, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    logic [127:0] mmul_exp;
`ifdef MATRIX_MUL_EN
    mmul_exp = '0;
`else
    mmul_exp = MBIG;
`endif
    #12;
    checkOutput("reset_valid", {127'd0, out_valid}, 128'd0);
    checkOutput("reset_alu", {96'd0, alu_o}, 128'd0);
    checkOutput("reset_mat", matrix_o, 128'd0);
    checkOutput("reset_br", {127'd0, br_mark}, 128'd0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus("add",    ALU_OP_ADD, 3'b000, 1'b0, 32'd1, 32'd2, M, 32'd3, M, 1'b0);
    applyStimulus("op111",  3'b111,     3'b000, 1'b0, 32'd1, 32'd2, M, 32'd3, M, 1'b0);
    applyStimulus("sub",    ALU_OP_R, 3'b000, 1'b1, 32'd5, 32'd7, M, 32'hFFFF_FFFE, M, 1'b0);
    applyStimulus("sra",    ALU_OP_R, 3'b101, 1'b1, 32'h8000_0000, 32'd4, M, 32'hF800_0000, M, 1'b0);
    applyStimulus("srl",    ALU_OP_R, 3'b101, 1'b0, 32'h8000_0000, 32'd4, M, 32'h0800_0000, M, 1'b0);
    applyStimulus("addi_f7",ALU_OP_I, 3'b000, 1'b1, 32'd10, 32'd20, M, 32'd30, M, 1'b0);
    applyStimulus("srai",   ALU_OP_I, 3'b101, 1'b1, 32'h8000_0000, 32'd4, M, 32'hF800_0000, M, 1'b0);
    applyStimulus("sll",    ALU_OP_R, 3'b001, 1'b0, 32'd1, 32'd35, M, 32'd8, M, 1'b0);
    applyStimulus("slt",    ALU_OP_R, 3'b010, 1'b0, 32'hFFFF_FFFF, 32'd1, M, 32'd1, M, 1'b0);
    applyStimulus("sltu",   ALU_OP_R, 3'b011, 1'b0, 32'hFFFF_FFFF, 32'd1, M, 32'd0, M, 1'b0);
    applyStimulus("xor",    ALU_OP_R, 3'b100, 1'b0, 32'hF0F0, 32'hFF00, M, 32'h0FF0, M, 1'b0);
    applyStimulus("or",     ALU_OP_R, 3'b110, 1'b0, 32'hF0F0, 32'hFF00, M, 32'hFFF0, M, 1'b0);
    applyStimulus("and",    ALU_OP_R, 3'b111, 1'b0, 32'hF0F0, 32'hFF00, M, 32'hF000, M, 1'b0);
    applyStimulus("lui",    ALU_OP_LUI, 3'b000, 1'b0, 32'd9, 32'h1234_5000, M, 32'h1234_5000, M, 1'b0);
    applyStimulus("blt",    ALU_OP_BR, 3'b100, 1'b0, 32'hFFFF_FFFF, 32'd1, M, 32'hFFFF_FFFE, M, 1'b1);
    applyStimulus("bltu",   ALU_OP_BR, 3'b110, 1'b0, 32'hFFFF_FFFF, 32'd1, M, 32'hFFFF_FFFE, M, 1'b0);
    applyStimulus("bge",    ALU_OP_BR, 3'b101, 1'b0, 32'hFFFF_FFFF, 32'd1, M, 32'hFFFF_FFFE, M, 1'b0);
    applyStimulus("bgeu",   ALU_OP_BR, 3'b111, 1'b0, 32'hFFFF_FFFF, 32'd1, M, 32'hFFFF_FFFE, M, 1'b1);
    applyStimulus("beq",    ALU_OP_BR, 3'b000, 1'b0, 32'd3, 32'd3, M, 32'd0, M, 1'b1);
    applyStimulus("bne",    ALU_OP_BR, 3'b001, 1'b0, 32'd3, 32'd3, M, 32'd0, M, 1'b0);
    applyStimulus("br010",  ALU_OP_BR, 3'b010, 1'b0, 32'd3, 32'd3, M, 32'd0, M, 1'b0);
    applyStimulus("jump",   ALU_OP_JMP, 3'b000, 1'b0, 32'h100, 32'd4, M, 32'h104, M, 1'b1);
    applyStimulus("madds",  ALU_OP_MAT, 3'b000, 1'b0, 32'd0, 32'd10, M, 32'd0,
                  {32'd14, 32'd13, 32'd12, 32'd11}, 1'b0);
    applyStimulus("mmuls",  ALU_OP_MAT, 3'b001, 1'b0, 32'd0, 32'h0001_0000, MBIG, 32'd0, mmul_exp, 1'b0);
    applyStimulus("msum",   ALU_OP_MAT, 3'b010, 1'b0, 32'd0, 32'd0, M, 32'd10, M, 1'b0);
    applyStimulus("mins",   ALU_OP_MAT, 3'b011, 1'b0, 32'd1, 32'd9, M, 32'd0,
                  {32'd4, 32'd3, 32'd9, 32'd1}, 1'b0);
    applyStimulus("mext",   ALU_OP_MAT, 3'b100, 1'b0, 32'd0, 32'd2, M, 32'd3, M, 1'b0);
    applyStimulus("mtrans", ALU_OP_MAT, 3'b101, 1'b0, 32'd0, 32'd0, M, 32'd0,
                  {32'd4, 32'd2, 32'd3, 32'd1}, 1'b0);
    applyStimulus("madd",   ALU_OP_MAT, 3'b110, 1'b0, 32'd5, 32'd0, M, 32'd1,
                  {32'd9, 32'd8, 32'd7, 32'd6}, 1'b0);
    applyStimulus("mbcast", ALU_OP_MAT, 3'b111, 1'b0, 32'd0, 32'd7, M, 32'd7, {4{32'd7}}, 1'b0);

    // Idle cycle: valid drops, data holds the broadcast result
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("hold_valid", {127'd0, out_valid}, 128'd0);
    checkOutput("hold_alu", {96'd0, alu_o}, 128'd7);
    checkOutput("hold_mat", matrix_o, {4{32'd7}});
    drain();

    // Reset while a result is being presented
    applyStimulus("pre_rst", ALU_OP_JMP, 3'b000, 1'b0, 32'd1, 32'd1, M, 32'd2, M, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("pre_rst_valid", {127'd0, out_valid}, 128'd1);
    rst = 1'b1;
    #1;
    checkOutput("rst_valid", {127'd0, out_valid}, 128'd0);
    checkOutput("rst_alu", {96'd0, alu_o}, 128'd0);
    checkOutput("rst_mat", matrix_o, 128'd0);
    checkOutput("rst_br", {127'd0, br_mark}, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("post_rst_valid", {127'd0, out_valid}, 128'd0);
    applyStimulus("post_rst", ALU_OP_ADD, 3'b000, 1'b0, 32'd2, 32'd2, M, 32'd4, M, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    done = 1'b1;
    $finish;
  end

  initial begin
    #100000;
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout: got no completion, expected finish before 100000");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

endmodule
